// File: rtl/clock_sel_ctrl.sv
// Request-side sequencer for the glitch-free 800/500/1000 MHz clock switch select.
// Defining CLOCK_SEL_QUEUE_EN adds a one-deep pending request slot.
module clock_sel_ctrl #(
   parameter int         SETTLE_CYC = 16,
   parameter logic [1:0] RST_SEL    = 2'b00
) (
   input  logic       clk_ref,
   input  logic       rst_clk_n,
   input  logic       req_valid,
   input  logic [1:0] req_sel,
   output logic       req_ready,
   input  logic       sel_lock,
   output logic [1:0] clk_sel,
   output logic       busy,
   output logic       switch_done
);

   localparam int               CNT_W     = $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   // The switch has no fourth source, so an out-of-range reset value maps to 1000 MHz.
   localparam logic [1:0]       RST_SEL_N = (RST_SEL == 2'b11) ? 2'b10 : RST_SEL;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [1:0]       req_sel_norm;
   logic             accept;
   logic             launch_en;
   logic [1:0]       launch_sel;

   assign req_sel_norm = (req_sel == 2'b11) ? 2'b10 : req_sel;
   assign accept       = req_valid & req_ready;

`ifdef CLOCK_SEL_QUEUE_EN
   logic       slot_full_reg;
   logic [1:0] slot_sel_reg;
   logic       slot_fill;

   // The slot is always drained in DONE, so it is empty whenever the FSM is idle.
   assign req_ready = ((state_reg == IDLE) | ~slot_full_reg) & ~sel_lock;
   assign slot_fill = accept & (state_reg == SETTLE);

   always_comb begin
      launch_en  = 1'b0;
      launch_sel = req_sel_norm;
      case (state_reg)
         IDLE: launch_en = accept;
         DONE: begin
            if (slot_full_reg) begin
               launch_en  = 1'b1;
               launch_sel = slot_sel_reg;
            end else begin
               launch_en  = accept;
            end
         end
         default: launch_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk_ref or negedge rst_clk_n) begin
      if (!rst_clk_n) begin
         slot_full_reg <= 1'b0;
         slot_sel_reg  <= RST_SEL_N;
      end else if (slot_fill) begin
         slot_full_reg <= 1'b1;
         slot_sel_reg  <= req_sel_norm;
      end else if (state_reg == DONE) begin
         slot_full_reg <= 1'b0;
      end
   end
`else
   assign req_ready  = (state_reg == IDLE) & ~sel_lock;
   assign launch_en  = accept;
   assign launch_sel = req_sel_norm;
`endif

   always_ff @(posedge clk_ref or negedge rst_clk_n) begin
      if (!rst_clk_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         clk_sel     <= RST_SEL_N;
         busy        <= 1'b0;
         switch_done <= 1'b0;
      end else begin
         switch_done <= 1'b0;
         case (state_reg)
            SETTLE: begin
               if (cnt_reg == '0) begin
                  state_reg   <= DONE;
                  busy        <= 1'b0;
                  switch_done <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - CNT_ONE;
               end
            end
            default: state_reg <= IDLE;
         endcase

         // A launch only happens from IDLE or DONE, never while a window is settling.
         if (launch_en) begin
            if (launch_sel != clk_sel) begin
               clk_sel   <= launch_sel;
               state_reg <= SETTLE;
               busy      <= 1'b1;
               cnt_reg   <= CNT_LOAD;
            end else begin
               state_reg   <= DONE;
               switch_done <= 1'b1;
            end
         end
      end
   end

   a_sel_legal: assert property (@(posedge clk_ref) disable iff (!rst_clk_n)
      clk_sel != 2'b11);

   a_busy_settle: assert property (@(posedge clk_ref) disable iff (!rst_clk_n)
      busy == (state_reg == SETTLE));

   a_sel_hold: assert property (@(posedge clk_ref) disable iff (!rst_clk_n)
      !launch_en |=> $stable(clk_sel));

endmodule

// File: tb/tb_clock_sel_ctrl.sv
// Bench for clock_sel_ctrl: table vectors, hand-written corner sequences and a random
// run against a timeline reference model (honours CLOCK_SEL_QUEUE_EN when defined).
module tb_clock_sel_ctrl;

   localparam int         SETTLE  = 16;
   localparam logic [1:0] RST_SEL = 2'b00;
`ifdef CLOCK_SEL_QUEUE_EN
   localparam bit QUEUE = 1'b1;
`else
   localparam bit QUEUE = 1'b0;
`endif

   logic       clk_ref = 1'b0;
   logic       rst_clk_n;
   logic       req_valid;
   logic [1:0] req_sel;
   logic       req_ready;
   logic       sel_lock;
   logic [1:0] clk_sel;
   logic       busy;
   logic       switch_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk_ref = ~clk_ref;

   clock_sel_ctrl #(
      .SETTLE_CYC (SETTLE),
      .RST_SEL    (RST_SEL)
   ) dut (
      .clk_ref     (clk_ref),
      .rst_clk_n   (rst_clk_n),
      .req_valid   (req_valid),
      .req_sel     (req_sel),
      .req_ready   (req_ready),
      .sel_lock    (sel_lock),
      .clk_sel     (clk_sel),
      .busy        (busy),
      .switch_done (switch_done)
   );

   // Reference model: absolute edge numbers at which each phase of a switch begins and ends.
   int         edge_cnt;
   logic [1:0] m_sel;
   int         busy_from, busy_to, done_at, idle_from;
   bit         slot_full;
   logic [1:0] slot_sel;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic logic [1:0] norm(input logic [1:0] s);
      return (s == 2'b11) ? 2'b10 : s;
   endfunction

   task automatic model_reset();
      m_sel     = RST_SEL;
      busy_from = 0;
      busy_to   = -1;
      done_at   = -1;
      idle_from = edge_cnt;
      slot_full = 1'b0;
      slot_sel  = 2'b00;
   endtask

   task automatic launch(input logic [1:0] s);
      if (s != m_sel) begin
         m_sel     = s;
         busy_from = edge_cnt;
         busy_to   = edge_cnt + SETTLE - 1;
         done_at   = edge_cnt + SETTLE;
         idle_from = edge_cnt + SETTLE + 1;
      end else begin
         busy_from = 0;
         busy_to   = -1;
         done_at   = edge_cnt;
         idle_from = edge_cnt + 1;
      end
   endtask

   // Called at a negedge with inputs already driven; compares, clocks once, returns at the next negedge.
   task automatic step();
      bit         m_idle, m_ready, m_busy, acc;
      int         e_old;
      logic [1:0] s_in;
      #1;
      m_idle  = (edge_cnt >= idle_from);
      m_ready = (m_idle || (QUEUE && !slot_full)) && !sel_lock;
      m_busy  = (edge_cnt >= busy_from) && (edge_cnt <= busy_to);
      chk("clk_sel", int'(clk_sel), int'(m_sel));
      chk("busy", int'(busy), int'(m_busy));
      chk("switch_done", int'(switch_done), int'(edge_cnt == done_at));
      chk("req_ready", int'(req_ready), int'(m_ready));
      acc   = req_valid && m_ready;
      s_in  = norm(req_sel);
      e_old = edge_cnt;
      @(posedge clk_ref);
      edge_cnt++;
      if (slot_full && e_old == done_at) begin
         launch(slot_sel);
         slot_full = 1'b0;
      end else if (acc && (m_idle || e_old == done_at)) begin
         launch(s_in);
      end else if (acc) begin
         slot_full = 1'b1;
         slot_sel  = s_in;
      end
      @(negedge clk_ref);
   endtask

   // Asserts reset between edges; outputs must return to reset values without a clock.
   task automatic do_reset_mid();
      #3;
      rst_clk_n = 1'b0;
      #1;
      chk("async_rst_clk_sel", int'(clk_sel), int'(RST_SEL));
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(switch_done), 0);
      model_reset();
      @(posedge clk_ref);
      @(posedge clk_ref);
      @(negedge clk_ref);
      rst_clk_n = 1'b1;
      $display("reset pulse applied at t=%0t", $time);
   endtask

   typedef struct {
      logic [1:0] sel;
      logic [1:0] exp_sel;
      int         exp_busy;
      int         exp_done;
   } vec_t;

   initial begin
      vec_t tbl [6];
      int   busy_cnt, done_off, done_cnt, first_done, second_done;

      tbl[0] = '{2'b01, 2'b01, SETTLE, SETTLE + 1};
      tbl[1] = '{2'b01, 2'b01, 0,      1};
      tbl[2] = '{2'b11, 2'b10, SETTLE, SETTLE + 1};
      tbl[3] = '{2'b10, 2'b10, 0,      1};
      tbl[4] = '{2'b00, 2'b00, SETTLE, SETTLE + 1};
      tbl[5] = '{2'b11, 2'b10, SETTLE, SETTLE + 1};

      rst_clk_n = 1'b0;
      req_valid = 1'b0;
      req_sel   = 2'b00;
      sel_lock  = 1'b0;
      edge_cnt  = 0;
      model_reset();
      repeat (3) @(posedge clk_ref);
      #1;
      chk("rst_clk_sel", int'(clk_sel), int'(RST_SEL));
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(switch_done), 0);
      @(negedge clk_ref);
      rst_clk_n = 1'b1;
      #1;
      chk("rst_ready", int'(req_ready), 1);
      @(negedge clk_ref);

      // Table vectors: one request each, measured from its accept edge.
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1;
         req_sel   = tbl[i].sel;
         step();
         req_valid = 1'b0;
         busy_cnt  = 0;
         done_off  = -1;
         for (int k = 1; k <= SETTLE + 4; k++) begin
            if (busy) busy_cnt++;
            if (switch_done && done_off < 0) done_off = k;
            step();
         end
         chk("tbl_busy_cycles", busy_cnt, tbl[i].exp_busy);
         chk("tbl_done_offset", done_off, tbl[i].exp_done);
         chk("tbl_clk_sel", int'(clk_sel), int'(tbl[i].exp_sel));
         $display("vec %0d req_sel=%b clk_sel=%b busy_cycles=%0d done_at=T+%0d",
                  i, tbl[i].sel, clk_sel, busy_cnt, done_off);
      end

      // Lock held with a pending request for 100 cycles, then released.
      sel_lock  = 1'b1;
      req_valid = 1'b1;
      req_sel   = 2'b01;
      repeat (100) step();
      chk("lock_hold_clk_sel", int'(clk_sel), 2);
      sel_lock = 1'b0;
      step();
      req_valid = 1'b0;
      chk("lock_release_accept", int'(clk_sel), 1);
      $display("lock release: clk_sel=%b", clk_sel);
      repeat (SETTLE + 3) step();

      // Lock raised at T+5 of a switch: the window still completes with done at T+17.
      req_valid = 1'b1;
      req_sel   = 2'b00;
      step();
      req_valid = 1'b0;
      repeat (4) step();
      sel_lock  = 1'b1;
      req_valid = 1'b1;
      req_sel   = 2'b10;
      done_off  = -1;
      for (int k = 5; k <= SETTLE + 20; k++) begin
         if (switch_done && done_off < 0) done_off = k;
         step();
      end
      chk("lock_mid_done_offset", done_off, SETTLE + 1);
      chk("lock_mid_clk_sel", int'(clk_sel), 0);
      $display("lock mid-settle: done_at=T+%0d clk_sel=%b", done_off, clk_sel);
      sel_lock  = 1'b0;
      req_valid = 1'b0;
      repeat (3) step();

      // Reset at T+8 of a switch discards it.
      req_valid = 1'b1;
      req_sel   = 2'b10;
      step();
      req_valid = 1'b0;
      repeat (7) step();
      do_reset_mid();
      repeat (SETTLE + 4) step();
      chk("post_reset_clk_sel", int'(clk_sel), int'(RST_SEL));

`ifdef CLOCK_SEL_QUEUE_EN
      // Back-to-back requests: the second waits in the slot and starts straight out of DONE.
      req_valid   = 1'b1;
      req_sel     = 2'b01;
      step();
      req_sel     = 2'b10;
      step();
      req_valid   = 1'b0;
      done_cnt    = 0;
      first_done  = -1;
      second_done = -1;
      for (int k = 2; k <= 2 * SETTLE + 6; k++) begin
         if (switch_done) begin
            done_cnt++;
            if (first_done < 0) first_done = k;
            else second_done = k;
         end
         step();
      end
      chk("queue_done_count", done_cnt, 2);
      chk("queue_first_done", first_done, SETTLE + 1);
      chk("queue_second_done", second_done, 2 * SETTLE + 2);
      chk("queue_clk_sel", int'(clk_sel), 2);
      $display("queue pair: done at T+%0d and T+%0d, clk_sel=%b", first_done, second_done, clk_sel);
`else
      done_cnt    = 0;
      first_done  = 0;
      second_done = 0;
`endif

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset_mid();
         req_valid = ($urandom_range(0, 1) == 1);
         req_sel   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 14) == 0) sel_lock = ~sel_lock;
         step();
      end
      sel_lock  = 1'b0;
      req_valid = 1'b0;
      repeat (2 * SETTLE + 6) step();
      $display("random phase complete at edge %0d", edge_cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, got t=%0t expected < 1000000", $time);
      $fatal(1);
   end

endmodule
